fibonacci_index: RTL and testbench
==================================

Name: fibonacci_index

Overview:
- Inverse of the Fibonacci generator: takes a R_W-bit value and returns the smallest index n with F(n) == value, or flags the value as not a Fibonacci number.
- Sequence convention matches the generator: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2). With defaults, F(0..7) = 0,1,1,2,3,5,8,13.
- Split into a datapath (value register, a/b pair, index counter, comparators) and a controller FSM, with the same start/done handshake as the generator.
- Sits downstream of the generator so its result can be checked or decoded back to n.

Parameters:
- N_W, 3, index width; maximum searched index MAX = 2^N_W - 1.
- R_W, 5, value width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request; sampled only in IDLE.
- value  input  R_W  number to decode; captured on the accepted start.
- n  output  N_W  decoded index; 0 when not found.
- found  output  1  1 = value is F(n); 0 = not a Fibonacci number within range.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state = IDLE; n = 0, found = 0, busy = 0, done = 0.
  - Internal a, b, idx and value register cleared.
  - Reset applies mid-operation; the search is abandoned and done does not pulse.
- Datapath widths:
  - a and b are R_W+1 bits wide, so a+b never wraps before it is compared.
  - idx is N_W bits wide.
  - The value register is R_W bits, compared zero-extended.
- FSM:
  - IDLE:
    - start=1 captures value into the value register; next state INIT.
    - start=0: remain in IDLE.
  - INIT: a=0, b=1, idx=0; next state CMP.
  - CMP:
    - a == value: set found=1, n=idx; next state DONE.
    - else if a > value or idx == MAX: set found=0, n=0; next state DONE.
    - else: next state STEP.
  - STEP: a <= b, b <= a+b, idx <= idx+1; next state CMP.
  - DONE: done=1 for exactly this cycle; next state IDLE.
- Latency, with start accepted at edge t:
  - CMP for index k is evaluated in cycle t+2+2k.
  - done is high in cycle t+3+2k, where k is the terminating index.
  - Worst case: done at t+17 for the defaults.
- Outputs:
  - n and found are registered.
  - They are valid in the done cycle and hold until the next accepted start.
  - They are cleared to 0 in the INIT cycle.
- Value 1 resolves to n=1 (the first match, since F(1) is reached before F(2)).
- Handshake:
  - start is ignored while busy=1 or done=1; it is not queued.
  - start held high continuously re-triggers in the IDLE cycle after DONE.
  - Changes on value after capture have no effect.
- busy = 1 in INIT, CMP, STEP and DONE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> n=0, found=0, busy=0, done=0; FSM stays in IDLE.
- value=0, start pulse at t -> done at t+3, n=0, found=1.
- value=13 -> done at t+17, n=7, found=1. Follow with value=1 -> done at t+5, n=1, found=1.
- value=4 -> search stops when a=5>4 at idx 5; done at t+13, n=0, found=0.
- value=20 and value=31 -> idx reaches 7 with a=13; done at t+17, n=0, found=0.
- Mid-operation: value=8 started, rst=0 at t+6 -> next cycle IDLE, outputs 0, no done pulse. Then start with value=8 -> done 15 cycles after the new start edge, n=6, found=1.
- Busy handshake: a start pulse during busy is ignored, and the result matches the first request only.

Source files
------------

// File: rtl/fibonacci_index.sv
// ============================================================================
// Module   : fibonacci_index
// Brief    : Decodes a value to the smallest n with F(n) == value, or flags it
//            as not a Fibonacci number within 0..2^N_W-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fibonacci_index #(
    parameter int N_W = 3,
    parameter int R_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [R_W-1:0] value,
    output logic [N_W-1:0] n,
    output logic           found,
    output logic           busy,
    output logic           done
);

    localparam logic [N_W-1:0] c_IDX_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_CMP  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    logic [R_W-1:0] r_value;
    logic [R_W:0]   r_a;
    logic [R_W:0]   r_b;
    logic [N_W-1:0] r_idx;

    logic w_eq;
    logic w_gt;
    logic w_last;

    // One extra bit on a/b keeps a+b from wrapping before the compare sees it
    assign w_eq   = (r_a == {1'b0, r_value});
    assign w_gt   = (r_a >  {1'b0, r_value});
    assign w_last = (r_idx == c_IDX_MAX);

    // Datapath: value capture and the (a, b, idx) walk along the sequence
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_value <= value;
            end
            if (r_state == S_INIT) begin
                r_a   <= '0;
                r_b   <= {{R_W{1'b0}}, 1'b1};
                r_idx <= '0;
            end
            if (r_state == S_STEP) begin
                r_a   <= r_b;
                r_b   <= r_a + r_b;
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Controller with registered result and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            n       <= '0;
            found   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= S_INIT;
                        busy    <= 1'b1;
                        n       <= '0;
                        found   <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    if (w_eq) begin
                        found   <= 1'b1;
                        n       <= r_idx;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_gt || w_last) begin
                        found   <= 1'b0;
                        n       <= '0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_state <= S_CMP;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fibonacci_index.sv
// ============================================================================
// Module   : tb_fibonacci_index
// Brief    : Scoreboard bench for fibonacci_index against a sequence-table model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fibonacci_index;

    localparam int N_W = 3;
    localparam int R_W = 5;
    localparam int MAX = (1 << N_W) - 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [R_W-1:0] value;
    logic [N_W-1:0] n;
    logic           found;
    logic           busy;
    logic           done;

    int errors;
    int checks;
    int cyc;

    typedef struct {
        int v;
        int n;
        bit f;
        int dcyc;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;

    fibonacci_index #(.N_W(N_W), .R_W(R_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .n     (n),
        .found (found),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: scan F(0..MAX) for the first match, stop at first overshoot or MAX
    function automatic void model(input int v, output int k, output int nn, output bit f);
        int fib[0:MAX];
        fib[0] = 0;
        fib[1] = 1;
        for (int i = 2; i <= MAX; i++) fib[i] = fib[i-1] + fib[i-2];
        k = MAX;
        f = 1'b0;
        for (int i = 0; i <= MAX; i++) begin
            if (fib[i] == v) begin
                k = i;
                f = 1'b1;
                break;
            end
            if (fib[i] > v) begin
                k = i;
                break;
            end
        end
        nn = f ? k : 0;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc + 1);
            end else begin
                e_mon = q.pop_front();
                checks += 3;
                if (int'(n) != e_mon.n) begin
                    errors++;
                    $display("FAIL n(value=%0d): got %0d, required %0d", e_mon.v, n, e_mon.n);
                end
                if (found != e_mon.f) begin
                    errors++;
                    $display("FAIL found(value=%0d): got %0d, required %0d", e_mon.v, found, e_mon.f);
                end
                if (cyc + 1 != e_mon.dcyc) begin
                    errors++;
                    $display("FAIL latency(value=%0d): done at cycle %0d, required %0d", e_mon.v, cyc + 1, e_mon.dcyc);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
        if (i == 100) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !busy) break;
        end
        if (i == 100) check("drain_timeout", q.size(), 0);
    endtask

    // Start one request; returns at the negedge inside the first CMP cycle
    task automatic issue(input int v, output int t);
        int k, nn;
        bit f;
        wait_idle();
        value = R_W'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        start = 1'b0;
        model(v, k, nn, f);
        q.push_back('{v: v, n: nn, f: f, dcyc: t + 3 + 2 * k});
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
        @(negedge clk);
        check("cleared_n_found", int'({n, found}), 0);
    endtask

    task automatic held_start(input int v, input int cnt);
        int k, nn, t, i;
        bit f;
        wait_idle();
        value = R_W'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        model(v, k, nn, f);
        for (int j = 0; j < cnt; j++) begin
            q.push_back('{v: v, n: nn, f: f, dcyc: t + 3 + 2 * k});
            t = t + 4 + 2 * k;
        end
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) break;
        end
        start = 1'b0;
        if (i == 200) check("held_start_timeout", q.size(), 0);
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        int dir[6] = '{0, 13, 1, 4, 20, 31};
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b0;
        start  = 1'b1;
        value  = 5'd13;

        // Reset held with start asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs", int'({n, found, busy, done}), 0);
        end
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_reset", int'({busy, done}), 0);

        // Directed values, including boundaries
        foreach (dir[i]) begin
            issue(dir[i], t);
            drain();
            check("hold_after_done_busy", int'(busy), 0);
        end

        // Reset mid-search abandons the request without a done pulse
        issue(8, t);
        for (int i = 0; i < 20 && cyc != t + 5; i++) @(negedge clk);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("midop_reset_outputs", int'({n, found, busy, done}), 0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) @(negedge clk);
        issue(8, t);
        drain();

        // Start pulses and value changes during busy are ignored
        issue(21, t);
        value = 5'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Start held high retriggers right after each DONE
        held_start(5, 3);

        // Randomized requests with random interference while busy
        for (int r = 0; r < 40; r++) begin
            issue(int'($urandom_range(0, (1 << R_W) - 1)), t);
            if ($urandom_range(0, 1) == 1) begin
                value = R_W'($urandom);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
